// File: rtl/camera_reg_if_mc.sv
// camera_reg_if_mc: cfg register file for N_CH uDMA RX channels plus double-buffered camera window/filter regs.
// Define CAM_FRAME_CNT_EN to add the 16-bit frame counter at word 0x17.
module camera_reg_if_mc #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int N_CH           = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [31:0]                    cfg_data_i,
    input  logic [5:0]                     cfg_addr_i,
    input  logic                           cfg_valid_i,
    input  logic                           cfg_rwn_i,
    output logic [31:0]                    cfg_data_o,
    output logic                           cfg_ready_o,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH*2-1:0]              cfg_rx_datasize_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_filter_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    input  logic                           cfg_cam_ip_en_i,
    input  logic                           frame_start_i,
    output logic [31:0]                    cfg_cam_cfg_o,
    output logic [31:0]                    cfg_cam_cfg_ll_o,
    output logic [31:0]                    cfg_cam_cfg_ur_o,
    output logic [31:0]                    cfg_cam_cfg_size_o,
    output logic [31:0]                    cfg_cam_cfg_filter_o
);
    logic [L2_AWIDTH_NOAL-1:0] r_saddr [N_CH];
    logic [TRANS_SIZE-1:0]     r_size  [N_CH];
    logic [1:0]                r_dsize [N_CH];
    logic [N_CH-1:0]           r_cont, r_filt, r_en, r_clr;
    logic [31:0]               r_sh [5];
    logic [31:0]               r_ac [5];
    logic                      r_pend;
    logic                      w_wr, w_upd, w_commit;
    logic [15:0]               w_cnt;

    assign w_wr     = cfg_valid_i & ~cfg_rwn_i;
    assign w_upd    = w_wr && cfg_addr_i == 6'h15 && cfg_data_i[0];
    // With the IP disabled actives simply track shadows; otherwise only a requested update lands, at frame start
    assign w_commit = ~cfg_cam_ip_en_i | (r_pend & frame_start_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_saddr <= '{default: '0};
            r_size  <= '{default: '0};
            r_dsize <= '{default: '0};
            r_cont  <= '0;
            r_filt  <= '0;
            r_en    <= '0;
            r_clr   <= '0;
            r_sh    <= '{default: '0};
            r_ac    <= '{default: '0};
            r_pend  <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_en[c]  <= w_wr && cfg_addr_i == 6'(4*c+2) && cfg_data_i[4];
                r_clr[c] <= w_wr && cfg_addr_i == 6'(4*c+2) && cfg_data_i[6];
                if (w_wr && cfg_addr_i == 6'(4*c))
                    r_saddr[c] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
                if (w_wr && cfg_addr_i == 6'(4*c+1))
                    r_size[c] <= cfg_data_i[TRANS_SIZE-1:0];
                if (w_wr && cfg_addr_i == 6'(4*c+2)) begin
                    r_filt[c]  <= cfg_data_i[3];
                    r_dsize[c] <= cfg_data_i[2:1];
                    r_cont[c]  <= cfg_data_i[0];
                end
            end
            for (int k = 0; k < 5; k++)
                if (w_wr && cfg_addr_i == 6'(16+k))
                    r_sh[k] <= cfg_data_i;
            if (w_commit)
                r_ac <= r_sh;
            r_pend <= ~w_commit & (r_pend | w_upd);
        end
    end

`ifdef CAM_FRAME_CNT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_cnt <= '0;
        else if (w_wr && cfg_addr_i == 6'h17)
            r_cnt <= '0;
        else if (frame_start_i && cfg_cam_ip_en_i)
            r_cnt <= r_cnt + 16'd1;
    end
    assign w_cnt = r_cnt;
`else
    assign w_cnt = '0;
`endif

    always_comb begin
        cfg_data_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_addr_i == 6'(4*c))
                cfg_data_o = 32'(cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
            if (cfg_addr_i == 6'(4*c+1))
                cfg_data_o = 32'(cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]);
            if (cfg_addr_i == 6'(4*c+2))
                cfg_data_o = {26'h0, cfg_rx_pending_i[c], cfg_rx_en_i[c], r_filt[c], r_dsize[c], r_cont[c]};
        end
        for (int k = 0; k < 5; k++)
            if (cfg_addr_i == 6'(16+k))
                cfg_data_o = r_sh[k];
        if (cfg_addr_i == 6'h10)
            cfg_data_o[31] = cfg_cam_ip_en_i;
        if (cfg_addr_i == 6'h16)
            cfg_data_o = {31'h0, r_pend};
        if (cfg_addr_i == 6'h17)
            cfg_data_o = {16'h0, w_cnt};
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = r_saddr[c];
        assign cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]               = r_size[c];
        assign cfg_rx_datasize_o[c*2 +: 2]                             = r_dsize[c];
    end

    assign cfg_ready_o          = 1'b1;
    assign cfg_rx_continuous_o  = r_cont;
    assign cfg_rx_filter_o      = r_filt;
    assign cfg_rx_en_o          = r_en;
    assign cfg_rx_clr_o         = r_clr;
    assign cfg_cam_cfg_o        = r_ac[0];
    assign cfg_cam_cfg_ll_o     = r_ac[1];
    assign cfg_cam_cfg_ur_o     = r_ac[2];
    assign cfg_cam_cfg_size_o   = r_ac[3];
    assign cfg_cam_cfg_filter_o = r_ac[4];
endmodule

// File: tb/tb_camera_reg_if_mc.sv
// tb_camera_reg_if_mc: directed spec scenarios plus random traffic against a transaction-level model.
module tb_camera_reg_if_mc;
    localparam int AW = 12, TS = 16, NC = 2;

    logic clk = 0, rst = 1;
    logic [31:0] cfg_data_i = 0;
    logic [5:0] cfg_addr_i = 0;
    logic cfg_valid_i = 0, cfg_rwn_i = 0, ip_en = 0, fs = 0;
    logic [NC-1:0] rx_en_i = 0, rx_pend_i = 0;
    logic [NC*AW-1:0] curr_i = 0;
    logic [NC*TS-1:0] left_i = 0;
    logic [31:0] rdata, cam_cfg, cam_ll, cam_ur, cam_size, cam_filt;
    logic ready;
    logic [NC*AW-1:0] o_saddr;
    logic [NC*TS-1:0] o_size;
    logic [NC*2-1:0] o_ds;
    logic [NC-1:0] o_cont, o_filt, o_en, o_clr;

    camera_reg_if_mc #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .N_CH(NC)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(rdata), .cfg_ready_o(ready),
        .cfg_rx_startaddr_o(o_saddr), .cfg_rx_size_o(o_size), .cfg_rx_datasize_o(o_ds),
        .cfg_rx_continuous_o(o_cont), .cfg_rx_filter_o(o_filt), .cfg_rx_en_o(o_en), .cfg_rx_clr_o(o_clr),
        .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend_i), .cfg_rx_curr_addr_i(curr_i),
        .cfg_rx_bytes_left_i(left_i), .cfg_cam_ip_en_i(ip_en), .frame_start_i(fs),
        .cfg_cam_cfg_o(cam_cfg), .cfg_cam_cfg_ll_o(cam_ll), .cfg_cam_cfg_ur_o(cam_ur),
        .cfg_cam_cfg_size_o(cam_size), .cfg_cam_cfg_filter_o(cam_filt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: programmed channel settings, shadow/active camera regs, update request, frame count
    logic [AW-1:0] m_saddr [NC];
    logic [TS-1:0] m_size [NC];
    logic [1:0] m_ds [NC];
    logic [NC-1:0] m_cont, m_filt, m_en, m_clr;
    logic [31:0] m_sh [5];
    logic [31:0] m_ac [5];
    logic m_pend;
    logic [15:0] m_cnt;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_saddr[c] = 0; m_size[c] = 0; m_ds[c] = 0;
        end
        m_cont = 0; m_filt = 0; m_en = 0; m_clr = 0;
        for (int k = 0; k < 5; k++) begin
            m_sh[k] = 0; m_ac[k] = 0;
        end
        m_pend = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] mread(logic [5:0] a);
        int c;
        c = int'(a) / 4;
        if (a < 16) begin
            if (c >= NC) return 0;
            case (a[1:0])
                2'd0: return 32'(curr_i[c*AW +: AW]);
                2'd1: return 32'(left_i[c*TS +: TS]);
                2'd2: return {26'h0, rx_pend_i[c], rx_en_i[c], m_filt[c], m_ds[c], m_cont[c]};
                default: return 0;
            endcase
        end
        if (a == 6'h10) return {ip_en, m_sh[0][30:0]};
        if (a >= 6'h11 && a <= 6'h14) return m_sh[int'(a) - 16];
        if (a == 6'h16) return {31'h0, m_pend};
`ifdef CAM_FRAME_CNT_EN
        if (a == 6'h17) return {16'h0, m_cnt};
`endif
        return 0;
    endfunction

    // One clock of the register file seen as a transaction: commit uses the shadows as they were before this write
    task automatic model_step();
        bit wr, commit;
        int c;
        wr = cfg_valid_i && !cfg_rwn_i;
        commit = !ip_en || (m_pend && fs);
        m_en = 0; m_clr = 0;
        if (commit) m_ac = m_sh;
        if (commit) m_pend = 0;
        else if (wr && cfg_addr_i == 6'h15 && cfg_data_i[0]) m_pend = 1;
        if (wr && cfg_addr_i < 16 && int'(cfg_addr_i) / 4 < NC) begin
            c = int'(cfg_addr_i) / 4;
            case (cfg_addr_i[1:0])
                2'd0: m_saddr[c] = cfg_data_i[AW-1:0];
                2'd1: m_size[c] = cfg_data_i[TS-1:0];
                2'd2: begin
                    m_en[c] = cfg_data_i[4]; m_clr[c] = cfg_data_i[6];
                    m_filt[c] = cfg_data_i[3]; m_ds[c] = cfg_data_i[2:1]; m_cont[c] = cfg_data_i[0];
                end
                default: ;
            endcase
        end
        if (wr && cfg_addr_i >= 6'h10 && cfg_addr_i <= 6'h14) m_sh[int'(cfg_addr_i) - 16] = cfg_data_i;
`ifdef CAM_FRAME_CNT_EN
        if (wr && cfg_addr_i == 6'h17) m_cnt = 0;
        else if (fs && ip_en) m_cnt = m_cnt + 1;
`endif
    endtask

    task automatic check_outs();
        logic [NC*AW-1:0] es;
        logic [NC*TS-1:0] ez;
        logic [NC*2-1:0] ed;
        for (int c = 0; c < NC; c++) begin
            es[c*AW +: AW] = m_saddr[c];
            ez[c*TS +: TS] = m_size[c];
            ed[c*2 +: 2] = m_ds[c];
        end
        check("saddr", o_saddr, es);
        check("size", o_size, ez);
        check("dsize", o_ds, ed);
        check("cont", o_cont, m_cont);
        check("filt", o_filt, m_filt);
        check("en", o_en, m_en);
        check("clr", o_clr, m_clr);
        check("cam_cfg", cam_cfg, m_ac[0]);
        check("cam_ll", cam_ll, m_ac[1]);
        check("cam_ur", cam_ur, m_ac[2]);
        check("cam_size", cam_size, m_ac[3]);
        check("cam_filt", cam_filt, m_ac[4]);
        check("ready", ready, 1);
    endtask

    task automatic step();
        #1;
        if (cfg_valid_i && cfg_rwn_i) check("rdata", rdata, mread(cfg_addr_i));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d);
        cfg_valid_i = 1; cfg_rwn_i = 0; cfg_addr_i = a; cfg_data_i = d;
        step();
        cfg_valid_i = 0;
    endtask

    task automatic rd(logic [5:0] a, logic [31:0] exp);
        cfg_valid_i = 1; cfg_rwn_i = 1; cfg_addr_i = a;
        #1;
        check($sformatf("rd_%0h", a), rdata, exp);
        step();
        cfg_valid_i = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        cfg_addr_i = 6'h16;
        #1 check("status_rst", rdata, 0);
        rst = 0;
        @(negedge clk);

        wr(6'h06, 32'h5B);
        check("ch1_pulse", {o_en, o_clr}, 4'b1010);
        check("ch1_cfg", {o_filt, o_ds, o_cont}, {2'b10, 4'b0100, 2'b10});
        step();
        check("ch1_pulse_end", {o_en, o_clr}, 4'b0000);
        rd(6'h03, 0);
        rd(6'h08, 0);

        ip_en = 1;
        wr(6'h11, 32'h00100020);
        check("ll_hold", cam_ll, 0);
        rd(6'h11, 32'h00100020);
        rd(6'h10, 32'h80000000);
        wr(6'h15, 1);
        rd(6'h16, 1);
        check("ll_wait", cam_ll, 0);
        fs = 1; step(); fs = 0;
        check("ll_commit", cam_ll, 32'h00100020);
        rd(6'h16, 0);

        wr(6'h12, 32'h1234);
        fs = 1; wr(6'h15, 1);
        check("coincide_hold", cam_ur, 0);
        fs = 0;
        rd(6'h16, 1);
        fs = 1; step(); fs = 0;
        check("coincide_commit", cam_ur, 32'h1234);

        ip_en = 0;
        wr(6'h12, 32'h0000ABCD);
        check("track_lag", cam_ur, 32'h1234);
        step();
        check("track", cam_ur, 32'h0000ABCD);

        ip_en = 1;
        wr(6'h13, 32'h55);
        wr(6'h15, 1);
        #2 rst = 1;
        #1 model_reset();
        check_outs();
        cfg_addr_i = 6'h16;
        #1 check("status_arst", rdata, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 800; i++) begin
            cfg_valid_i = 1'($urandom);
            cfg_rwn_i = 1'($urandom);
            cfg_addr_i = ($urandom % 10 == 0) ? 6'($urandom) : 6'($urandom_range(0, 25));
            cfg_data_i = $urandom;
            fs = ($urandom % 6 == 0);
            if ($urandom % 20 == 0) ip_en = ~ip_en;
            rx_en_i = NC'($urandom);
            rx_pend_i = NC'($urandom);
            curr_i = (NC*AW)'($urandom);
            left_i = (NC*TS)'($urandom);
            step();
        end
        cfg_valid_i = 0; fs = 0;

`ifdef CAM_FRAME_CNT_EN
        ip_en = 1;
        wr(6'h17, 0);
        rd(6'h17, 0);
        fs = 1;
        for (int i = 0; i < 32'h10001; i++) step();
        fs = 0;
        rd(6'h17, 1);
        fs = 1; wr(6'h17, 0); fs = 0;
        rd(6'h17, 0);
`else
        wr(6'h17, 32'hFFFF);
        rd(6'h17, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
